// File: rtl/instr_load_pkg.sv
// Shared definitions for the instruction memory loader.
//   load_state_e : loader FSM state encoding
//   WORD_BYTES   : bytes packed into one instruction word
//   ADDR_STEP    : byte-address increment between consecutive words
//   word_addr()  : byte address of word 'idx' relative to 'base'
package instr_load_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } load_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] ADDR_STEP  = 32'd4;

    // Wraps modulo 2^32; cannot wrap in legal use since idx < N.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * ADDR_STEP;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-write signals.
//   start/word_count               : load request (from boot/debug control)
//   byte_valid/byte_data/byte_ready: byte stream handshake
//   mem_we/mem_addr/mem_wdata      : instruction memory write port
//   busy/done/error                : load status
// master : the side that requests loads and supplies bytes
// slave  : the loader itself
interface instr_mem_loader_if;

    logic        start;
    logic [31:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shift register with a 2-bit byte counter.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   shift_en   : a byte is accepted this cycle
//   byte_data  : accepted byte
//   word_next  : word as it will be after shifting in byte_data
//   word_full  : the byte accepted this cycle completes a word
module byte_packer
    import instr_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    assign word_next = {word_q[23:0], byte_data};
    // Look-ahead so the write strobe can be registered on the same edge as the last byte.
    assign word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next;
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a program into instruction memory from a byte stream.
// Bytes are packed big-endian into 32-bit words; each word is written once at
// consecutive word-aligned byte addresses starting at BASE_ADDR.
//   N         : instruction memory depth in words
//   BASE_ADDR : byte address of the first word (word-aligned)
//   clk, rst  : clock, synchronous active-high reset
//   bus       : control, byte stream, memory write port and status (slave side)
module instr_mem_loader
    import instr_load_pkg::*;
#(
    parameter int unsigned N         = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);

    load_state_e state_q;
    logic [31:0] count_q;
    logic [31:0] word_idx_q;
    logic        byte_ready_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic        pack_clear;
    logic        word_full;
    logic [31:0] word_next;
    logic        count_zero;
    logic        count_over;

    assign accept     = bus.byte_valid && byte_ready_q;
    assign pack_clear = (state_q == StIdle) && bus.start;
    assign count_zero = (bus.word_count == 32'd0);
    assign count_over = (bus.word_count > 32'(N));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .shift_en  (accept),
        .byte_data (bus.byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (count_zero) begin
                            error_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (count_over) begin
                            // Reject without consuming any bytes.
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            count_q      <= bus.word_count;
                            word_idx_q   <= '0;
                            error_q      <= 1'b0;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                            state_q      <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (word_full) begin
                        byte_ready_q <= 1'b0;
                        mem_we_q     <= 1'b1;
                        mem_wdata_q  <= word_next;
                        mem_addr_q   <= word_addr(BASE_ADDR, word_idx_q);
                        state_q      <= StWrite;
                    end
                end
                StWrite: begin
                    mem_we_q   <= 1'b0;
                    word_idx_q <= word_idx_q + 32'd1;
                    if (word_idx_q == count_q - 32'd1) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= StCollect;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader. Two instances (BASE_ADDR 0 and 32'h100,
// both N=4) see the same stimulus; writes are recorded per cycle at the negedge.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_mem_loader_if bus0 ();
    instr_mem_loader_if bus1 ();

    assign bus1.start      = bus0.start;
    assign bus1.word_count = bus0.word_count;
    assign bus1.byte_valid = bus0.byte_valid;
    assign bus1.byte_data  = bus0.byte_data;

    instr_mem_loader #(.N(4), .BASE_ADDR(32'h0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instr_mem_loader #(.N(4), .BASE_ADDR(32'h100)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          start_cyc;
    int          wr_n;
    int          done_n;
    int          done_cyc;
    logic        ready_seen;
    logic        busy_seen;
    logic [31:0] wr_addr  [8];
    logic [31:0] wr_data  [8];
    logic [31:0] wr1_addr [8];
    logic [31:0] wr1_data [8];
    int          wr_cyc   [8];
    logic [7:0]  stim     [16];

    task automatic sample();
        cyc++;
        if (bus0.mem_we) begin
            if (wr_n < 8) begin
                wr_addr[wr_n]  = bus0.mem_addr;
                wr_data[wr_n]  = bus0.mem_wdata;
                wr1_addr[wr_n] = bus1.mem_addr;
                wr1_data[wr_n] = bus1.mem_wdata;
                wr_cyc[wr_n]   = cyc;
            end
            wr_n++;
        end
        if (bus0.done) begin
            if (done_n == 0) done_cyc = cyc;
            done_n++;
        end
        if (bus0.byte_ready) ready_seen = 1'b1;
        if (bus0.busy) busy_seen = 1'b1;
    endtask

    task automatic clear_rec();
        wr_n       = 0;
        done_n     = 0;
        done_cyc   = -1;
        ready_seen = 1'b0;
        busy_seen  = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] count);
        @(negedge clk);
        sample();
        start_cyc       = cyc;
        bus0.start      = 1'b1;
        bus0.word_count = count;
    endtask

    // Supplies stim[0..nbytes-1] whenever byte_ready is high and no gap is
    // requested; pulses start per 'spur' and changes word_count after the real
    // start. Returns on the negedge where done is first seen.
    task automatic feed(input int nbytes, input logic [63:0] gaps, input logic [63:0] spur);
        int   idx = 0;
        int   k = 0;
        logic fin = 1'b0;
        logic g;
        logic sp;
        while (!fin && k < 400) begin
            @(negedge clk);
            sample();
            fin = (done_n > 0);
            g  = (k < 64) ? gaps[k[5:0]] : 1'b0;
            sp = (k < 64) ? spur[k[5:0]] : 1'b0;
            bus0.start      = sp && !fin;
            bus0.word_count = 32'd1;
            if (!fin && idx < nbytes && bus0.byte_ready && !g) begin
                bus0.byte_valid = 1'b1;
                bus0.byte_data  = stim[idx];
                idx++;
            end else begin
                bus0.byte_valid = 1'b0;
            end
            k++;
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL feed_timeout: done not seen after %0d cycles, want within 400", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors += 7;
        if (bus0.byte_ready !== 1'b0) begin miscompares++; $display("FAIL rst_byte_ready: got %b want 0", bus0.byte_ready); end
        if (bus0.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b want 0", bus0.mem_we); end
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus0.busy); end
        if (bus0.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", bus0.done); end
        if (bus0.error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b want 0", bus0.error); end
        if (bus0.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", bus0.mem_addr); end
        if (bus0.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h want 0", bus0.mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        stim = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_rec();
        do_start(32'd2);
        feed(8, 64'h0, 64'h0);
        vectors += 9;
        if (wr_n !== 2) begin miscompares++; $display("FAIL b2b_writes: got %0d want 2", wr_n); end
        if (wr_addr[0] !== 32'h0) begin miscompares++; $display("FAIL b2b_addr0: got %h want 00000000", wr_addr[0]); end
        if (wr_data[0] !== 32'h20010005) begin miscompares++; $display("FAIL b2b_data0: got %h want 20010005", wr_data[0]); end
        if (wr_addr[1] !== 32'h4) begin miscompares++; $display("FAIL b2b_addr1: got %h want 00000004", wr_addr[1]); end
        if (wr_data[1] !== 32'h8C220004) begin miscompares++; $display("FAIL b2b_data1: got %h want 8c220004", wr_data[1]); end
        if (wr_cyc[0] - start_cyc !== 5) begin miscompares++; $display("FAIL b2b_first_we_latency: got %0d want 5", wr_cyc[0] - start_cyc); end
        if (wr_cyc[1] - wr_cyc[0] !== 5) begin miscompares++; $display("FAIL b2b_we_spacing: got %0d want 5", wr_cyc[1] - wr_cyc[0]); end
        if (done_cyc - start_cyc !== 11) begin miscompares++; $display("FAIL b2b_done_latency: got %0d want 11", done_cyc - start_cyc); end
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_in_done: got %b want 0", bus0.busy); end
        @(negedge clk);
        sample();
        vectors += 3;
        if (bus0.done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_pulse_width: got %b want 0", bus0.done); end
        if (done_n !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", done_n); end
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_after: got %b want 0", bus0.busy); end
    endtask

    task automatic test_error();
        stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_rec();
        do_start(32'd5);
        feed(4, 64'h0, 64'h0);
        vectors += 5;
        if (bus0.error !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", bus0.error); end
        if (done_cyc - start_cyc !== 1) begin miscompares++; $display("FAIL err_done_latency: got %0d want 1", done_cyc - start_cyc); end
        if (ready_seen !== 1'b0) begin miscompares++; $display("FAIL err_byte_ready_seen: got %b want 0", ready_seen); end
        if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL err_busy_seen: got %b want 0", busy_seen); end
        if (wr_n !== 0) begin miscompares++; $display("FAIL err_writes: got %0d want 0", wr_n); end
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        vectors++;
        if (bus0.error !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", bus0.error); end
        // Legal load of one word clears the error.
        clear_rec();
        do_start(32'd1);
        @(negedge clk);
        sample();
        bus0.start = 1'b0;
        vectors++;
        if (bus0.error !== 1'b0) begin miscompares++; $display("FAIL err_clear_on_start: got %b want 0", bus0.error); end
        feed(4, 64'h0, 64'h0);
        vectors += 3;
        if (wr_n !== 1) begin miscompares++; $display("FAIL err_reload_writes: got %0d want 1", wr_n); end
        if (wr_data[0] !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL err_reload_data: got %h want a1b2c3d4", wr_data[0]); end
        if (wr_addr[0] !== 32'h0) begin miscompares++; $display("FAIL err_reload_addr: got %h want 00000000", wr_addr[0]); end
    endtask

    task automatic test_zero_count();
        // Set error first so the zero-count start has something to clear.
        clear_rec();
        do_start(32'd9);
        feed(0, 64'h0, 64'h0);
        vectors++;
        if (bus0.error !== 1'b1) begin miscompares++; $display("FAIL zero_pre_error: got %b want 1", bus0.error); end
        clear_rec();
        do_start(32'd0);
        feed(0, 64'h0, 64'h0);
        vectors += 5;
        if (done_cyc - start_cyc !== 1) begin miscompares++; $display("FAIL zero_done_latency: got %0d want 1", done_cyc - start_cyc); end
        if (wr_n !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", wr_n); end
        if (bus0.error !== 1'b0) begin miscompares++; $display("FAIL zero_error: got %b want 0", bus0.error); end
        if (ready_seen !== 1'b0) begin miscompares++; $display("FAIL zero_byte_ready_seen: got %b want 0", ready_seen); end
        if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL zero_busy_seen: got %b want 0", busy_seen); end
    endtask

    task automatic test_gaps_and_spurious_start();
        stim = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_rec();
        do_start(32'd2);
        feed(8, 64'h0000_0000_0F0C_A5A6, 64'h0000_0000_0010_4208);
        vectors += 6;
        if (wr_n !== 2) begin miscompares++; $display("FAIL gap_writes: got %0d want 2", wr_n); end
        if (wr_addr[0] !== 32'h0) begin miscompares++; $display("FAIL gap_addr0: got %h want 00000000", wr_addr[0]); end
        if (wr_data[0] !== 32'h20010005) begin miscompares++; $display("FAIL gap_data0: got %h want 20010005", wr_data[0]); end
        if (wr_addr[1] !== 32'h4) begin miscompares++; $display("FAIL gap_addr1: got %h want 00000004", wr_addr[1]); end
        if (wr_data[1] !== 32'h8C220004) begin miscompares++; $display("FAIL gap_data1: got %h want 8c220004", wr_data[1]); end
        if (done_n !== 1) begin miscompares++; $display("FAIL gap_done_count: got %0d want 1", done_n); end
    endtask

    task automatic test_reset_mid_word();
        clear_rec();
        do_start(32'd1);
        @(negedge clk);
        sample();
        bus0.start      = 1'b0;
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = 8'hAA;
        @(negedge clk);
        sample();
        bus0.byte_data = 8'hBB;
        @(negedge clk);
        sample();
        bus0.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        sample();
        rst = 1'b0;
        vectors += 8;
        if (bus0.byte_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_byte_ready: got %b want 0", bus0.byte_ready); end
        if (bus0.mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_mem_we: got %b want 0", bus0.mem_we); end
        if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", bus0.busy); end
        if (bus0.done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", bus0.done); end
        if (bus0.error !== 1'b0) begin miscompares++; $display("FAIL mid_rst_error: got %b want 0", bus0.error); end
        if (bus0.mem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_mem_addr: got %h want 0", bus0.mem_addr); end
        if (bus0.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_mem_wdata: got %h want 0", bus0.mem_wdata); end
        if (wr_n !== 0) begin miscompares++; $display("FAIL mid_rst_writes: got %0d want 0", wr_n); end
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_rec();
        do_start(32'd1);
        feed(4, 64'h0, 64'h0);
        vectors += 3;
        if (wr_n !== 1) begin miscompares++; $display("FAIL mid_reload_writes: got %0d want 1", wr_n); end
        if (wr_addr[0] !== 32'h0) begin miscompares++; $display("FAIL mid_reload_addr: got %h want 00000000", wr_addr[0]); end
        if (wr_data[0] !== 32'h11223344) begin miscompares++; $display("FAIL mid_reload_data: got %h want 11223344", wr_data[0]); end
    endtask

    // Full-depth load (count == N) checked on both base addresses.
    task automatic test_base_addr();
        stim = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        clear_rec();
        do_start(32'd4);
        feed(16, 64'h0, 64'h0);
        vectors += 9;
        if (wr_n !== 4) begin miscompares++; $display("FAIL base_writes: got %0d want 4", wr_n); end
        if (bus0.error !== 1'b0) begin miscompares++; $display("FAIL base_error: got %b want 0", bus0.error); end
        if (wr1_addr[0] !== 32'h100) begin miscompares++; $display("FAIL base_addr0: got %h want 00000100", wr1_addr[0]); end
        if (wr1_addr[1] !== 32'h104) begin miscompares++; $display("FAIL base_addr1: got %h want 00000104", wr1_addr[1]); end
        if (wr1_addr[3] !== 32'h10C) begin miscompares++; $display("FAIL base_addr3: got %h want 0000010c", wr1_addr[3]); end
        if (wr1_data[0] !== 32'h00112233) begin miscompares++; $display("FAIL base_data0: got %h want 00112233", wr1_data[0]); end
        if (wr1_data[3] !== 32'hCCDDEEFF) begin miscompares++; $display("FAIL base_data3: got %h want ccddeeff", wr1_data[3]); end
        if (wr_addr[3] !== 32'hC) begin miscompares++; $display("FAIL base0_addr3: got %h want 0000000c", wr_addr[3]); end
        if (wr_data[2] !== 32'h8899AABB) begin miscompares++; $display("FAIL base0_data2: got %h want 8899aabb", wr_data[2]); end
    endtask

    initial begin
        rst             = 1'b1;
        bus0.start      = 1'b0;
        bus0.word_count = 32'd0;
        bus0.byte_valid = 1'b0;
        bus0.byte_data  = 8'h00;
        clear_rec();
        test_reset();
        test_back_to_back();
        test_error();
        test_zero_count();
        test_gaps_and_spurious_start();
        test_reset_mid_word();
        test_base_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writes program words into the instruction memory from a byte stream, so a program can be loaded at run time instead of only from the initialisation file. Accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit instructions. Issues one write per word at consecutive word-aligned byte addresses. Sits between the boot/debug byte source and the instruction memory's write port, and holds the CPU off (via `busy`) while loading.

## Interface
- `N`, 1: instruction memory depth in words; must match the memory's `N`.
- `BASE_ADDR`, 32'h0: byte address of the first word written; word-aligned.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `word_count`  in  32  number of words to load; sampled with `start`.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  byte value.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address; memory indexes by `mem_addr >> 2`.
- `mem_wdata`  out  32  instruction word.
- `busy`  out  1  load in progress; CPU must stay stalled or held in reset.
- `done`  out  1  one-cycle pulse at end of every accepted `start`.
- `error`  out  1  sticky; set when `word_count > N`; cleared by the next accepted `start` or `rst`.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- Reset values: state IDLE; `byte_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_wdata` = 0; byte and word counters = 0.
- IDLE, `start`=1:
  - `word_count`==0: go to DONE; no writes; `error`=0.
  - `word_count`>N: `error`=1, go to DONE; no bytes consumed.
  - Otherwise: latch count, clear counters, `error`=0, go to COLLECT.
- COLLECT: `byte_ready`=1, `busy`=1.
  - On `byte_valid & byte_ready`: `word <= {word[23:0], byte_data}`; increment the byte index (2 bits).
  - After the 4th byte is accepted, go to WRITE.
- WRITE: `mem_we`=1, `mem_wdata`=assembled word, `mem_addr`=`BASE_ADDR + 4*word_idx`, `byte_ready`=0.
  - Then increment `word_idx`.
  - Go to DONE if this was word `count-1`, otherwise back to COLLECT.
- DONE: `done`=1 for one cycle, `busy`=0, `byte_ready`=0; then IDLE.
- `start` outside IDLE is ignored.
- Address arithmetic is 32-bit unsigned, wrapping modulo 2^32; it cannot wrap in legal use because the count is at most N.
- `rst` at any point (mid-word or mid-load) discards the partial word, issues no write, and returns to IDLE with the reset values above.

## Timing
- All outputs are registered.
- A byte transfers on the rising edge where `byte_valid & byte_ready`.
- `mem_we` is high in the cycle immediately after the edge accepting the 4th byte. `mem_addr` and `mem_wdata` are stable throughout that cycle.
- Throughput with a continuous source: 5 cycles per word (4 COLLECT, 1 WRITE).
- `done` is high in the cycle after the last WRITE cycle. For a zero-count or error `start`, `done` is high in the cycle after `start`.
- `busy` rises the cycle after an accepted non-zero, legal `start` and falls in the DONE cycle.
- Source gaps (`byte_valid`=0) stall COLLECT indefinitely with no timeout.

## Structure
- Shared package `instr_load_pkg`:
  - state encoding constants (IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2, DONE=2'd3);
  - `WORD_BYTES`=4;
  - `ADDR_STEP`=4.
- One sub-module, `byte_packer`: 32-bit shift register plus 2-bit byte counter, with a `word_full` flag. The FSM, word counter and address generation stay in the top level.

## Test plan
- N=4, `start` with `word_count`=2, bytes 20 01 00 05 8C 22 00 04 back-to-back -> `mem_we` at addr 0 with 32'h20010005, then at addr 4 with 32'h8C220004, 5 cycles apart; one `done` pulse; `busy` low afterwards.
- `word_count`=0 -> `done` the cycle after `start`; no `mem_we`; `error`=0; `byte_ready` never high.
- N=4, `word_count`=5 -> `error`=1 and `done` pulse; no bytes accepted. Then a legal `start` with count 1 -> `error` clears.
- Random `byte_valid` gaps, plus `start` pulses during COLLECT -> same writes and data as the gap-free run; extra `start` pulses have no effect.
- `rst` after 2 bytes of word 0 -> no `mem_we`; all outputs 0. A new load of 1 word then writes addr 0 with only the new 4 bytes.
- `BASE_ADDR`=32'h100, `word_count`=2 -> writes at 32'h100 and 32'h104.
